// File: rtl/inference_sequencer.sv
// Runs the weight-load -> bias-load -> FC-compute chain of every inference stage
// in order, with one-cycle start pulses, per-step timeout, abort and run timing.
module inference_sequencer #(
   parameter int NUM_STAGES     = 3,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic                  clk_100MHz,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  abort,
   output logic [NUM_STAGES-1:0] wl_start,
   input  logic [NUM_STAGES-1:0] wl_done,
   output logic [NUM_STAGES-1:0] bl_start,
   input  logic [NUM_STAGES-1:0] bl_done,
   output logic [NUM_STAGES-1:0] fc_start,
   input  logic [NUM_STAGES-1:0] fc_done,
   output logic [NUM_STAGES-1:0] stage_done,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic [2:0]            err_stage,
   output logic [1:0]            err_step,
   output logic [31:0]           run_cycles,
   output logic [2:0]            dbg_state
);
   // Handshake: *_start[s] is a one-cycle request; the matching *_done[s] (level or
   // pulse) is accepted on any later cycle of that step, never in the pulse cycle.
   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_WLOAD   = 3'd1,
      S_BLOAD   = 3'd2,
      S_COMPUTE = 3'd3,
      S_ERROR   = 3'd4
   } state_t;

   state_t                r_state, w_state_nxt;
   logic [2:0]            r_s, w_s_nxt;
   logic [31:0]           r_wait, w_wait_nxt;
   logic [31:0]           r_run_cnt, w_run_cnt_nxt, w_run_inc;
   logic                  r_entry, w_entry_nxt;
   logic [NUM_STAGES-1:0] r_wl_start, w_wl_start_nxt;
   logic [NUM_STAGES-1:0] r_bl_start, w_bl_start_nxt;
   logic [NUM_STAGES-1:0] r_fc_start, w_fc_start_nxt;
   logic [NUM_STAGES-1:0] r_stage_done, w_stage_done_nxt;
   logic                  r_done, w_done_nxt;
   logic                  r_busy, w_busy_nxt;
   logic                  r_error, w_error_nxt;
   logic [2:0]            r_err_stage, w_err_stage_nxt;
   logic [1:0]            r_err_step, w_err_step_nxt;
   logic [31:0]           r_run_cycles, w_run_cycles_nxt;
   logic [NUM_STAGES-1:0] w_cur_bit, w_next_bit;
   logic                  w_step_done, w_accept, w_last, w_timeout;
   logic [1:0]            w_step_code;

   assign w_cur_bit  = NUM_STAGES'(1) << r_s;
   assign w_next_bit = NUM_STAGES'(1) << (r_s + 3'd1);
   assign w_last     = (r_s == 3'(NUM_STAGES - 1));
   assign w_timeout  = (r_wait == 32'(TIMEOUT_CYCLES));
   assign w_run_inc  = (r_run_cnt == 32'hFFFF_FFFF) ? r_run_cnt : r_run_cnt + 32'd1;
   assign w_accept   = w_step_done & ~r_entry;

   // Only the current stage's done bit is observed
   always_comb begin
      w_step_done = 1'b0;
      w_step_code = 2'd0;
      case (r_state)
         S_WLOAD:   begin w_step_done = |(wl_done & w_cur_bit); w_step_code = 2'd1; end
         S_BLOAD:   begin w_step_done = |(bl_done & w_cur_bit); w_step_code = 2'd2; end
         S_COMPUTE: begin w_step_done = |(fc_done & w_cur_bit); w_step_code = 2'd3; end
         default:   ;
      endcase
   end

   always_comb begin
      w_state_nxt      = r_state;
      w_s_nxt          = r_s;
      w_wait_nxt       = r_wait;
      w_run_cnt_nxt    = r_run_cnt;
      w_entry_nxt      = 1'b0;
      w_wl_start_nxt   = '0;
      w_bl_start_nxt   = '0;
      w_fc_start_nxt   = '0;
      w_stage_done_nxt = '0;
      w_done_nxt       = 1'b0;
      w_error_nxt      = r_error;
      w_err_stage_nxt  = r_err_stage;
      w_err_step_nxt   = r_err_step;
      w_run_cycles_nxt = r_run_cycles;
      if (abort) begin
         // Abort also masks a start request arriving in IDLE or ERROR
         w_state_nxt = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE, S_ERROR: begin
               if (start) begin
                  w_error_nxt     = 1'b0;
                  w_err_stage_nxt = 3'd0;
                  w_err_step_nxt  = 2'd0;
                  w_s_nxt         = 3'd0;
                  w_state_nxt     = S_WLOAD;
                  w_wl_start_nxt  = NUM_STAGES'(1);
                  w_entry_nxt     = 1'b1;
                  w_wait_nxt      = 32'd0;
                  w_run_cnt_nxt   = 32'd0;
               end
            end
            S_WLOAD, S_BLOAD, S_COMPUTE: begin
               w_run_cnt_nxt = w_run_inc;
               w_wait_nxt    = r_wait + 32'd1;
               if (w_accept) begin
                  w_entry_nxt = 1'b1;
                  w_wait_nxt  = 32'd0;
                  if (r_state == S_WLOAD) begin
                     w_state_nxt    = S_BLOAD;
                     w_bl_start_nxt = w_cur_bit;
                  end else if (r_state == S_BLOAD) begin
                     w_state_nxt    = S_COMPUTE;
                     w_fc_start_nxt = w_cur_bit;
                  end else begin
                     w_stage_done_nxt = w_cur_bit;
                     if (w_last) begin
                        w_state_nxt      = S_IDLE;
                        w_done_nxt       = 1'b1;
                        w_run_cycles_nxt = w_run_inc;
                     end else begin
                        w_state_nxt    = S_WLOAD;
                        w_s_nxt        = r_s + 3'd1;
                        w_wl_start_nxt = w_next_bit;
                     end
                  end
               end else if (w_timeout) begin
                  w_state_nxt     = S_ERROR;
                  w_error_nxt     = 1'b1;
                  w_err_stage_nxt = r_s;
                  w_err_step_nxt  = w_step_code;
               end
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end
      w_busy_nxt = (w_state_nxt == S_WLOAD) || (w_state_nxt == S_BLOAD) ||
                   (w_state_nxt == S_COMPUTE);
   end

   always_ff @(posedge clk_100MHz) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_s          <= 3'd0;
         r_wait       <= 32'd0;
         r_run_cnt    <= 32'd0;
         r_entry      <= 1'b0;
         r_wl_start   <= '0;
         r_bl_start   <= '0;
         r_fc_start   <= '0;
         r_stage_done <= '0;
         r_done       <= 1'b0;
         r_busy       <= 1'b0;
         r_error      <= 1'b0;
         r_err_stage  <= 3'd0;
         r_err_step   <= 2'd0;
         r_run_cycles <= 32'd0;
      end else begin
         r_state      <= w_state_nxt;
         r_s          <= w_s_nxt;
         r_wait       <= w_wait_nxt;
         r_run_cnt    <= w_run_cnt_nxt;
         r_entry      <= w_entry_nxt;
         r_wl_start   <= w_wl_start_nxt;
         r_bl_start   <= w_bl_start_nxt;
         r_fc_start   <= w_fc_start_nxt;
         r_stage_done <= w_stage_done_nxt;
         r_done       <= w_done_nxt;
         r_busy       <= w_busy_nxt;
         r_error      <= w_error_nxt;
         r_err_stage  <= w_err_stage_nxt;
         r_err_step   <= w_err_step_nxt;
         r_run_cycles <= w_run_cycles_nxt;
      end
   end

   assign wl_start   = r_wl_start;
   assign bl_start   = r_bl_start;
   assign fc_start   = r_fc_start;
   assign stage_done = r_stage_done;
   assign busy       = r_busy;
   assign done       = r_done;
   assign error      = r_error;
   assign err_stage  = r_err_stage;
   assign err_step   = r_err_step;
   assign run_cycles = r_run_cycles;
   assign dbg_state  = r_state;

endmodule

// File: doc/inference_sequencer.md
# inference_sequencer

Sequences the weight-loader → bias-loader → fully-connected compute chain of the inference datapath through a configurable number of stages, replacing the hard-wired done-to-start daisy chain between loaders and FC units. It sits between the UART front-end FSM, which issues `start` once all 64 input bytes are buffered, and the per-stage loader/FC instances. It provides one-cycle start pulses, done handshakes, per-step timeout supervision, abort, and a run-length cycle count.

## Interface
- `NUM_STAGES`, 3: number of load/compute stages. Two layer-1 halves plus layer 2. Legal range 1–8.
- `TIMEOUT_CYCLES`, 100000: maximum wait cycles for any single `*_done`. Must be ≥ 2.
- `clk_100MHz`  in  1  system clock; everything is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  run request. Sampled only in IDLE.
- `abort`  in  1  cancel the current run. Has priority over every other input except `rst`.
- `wl_start`  out  NUM_STAGES  one-hot, one-cycle weight-loader start pulse for stage i.
- `wl_done`  in  NUM_STAGES  weight-loader done for stage i. Level or pulse.
- `bl_start`  out  NUM_STAGES  bias-loader start pulse.
- `bl_done`  in  NUM_STAGES  bias-loader done.
- `fc_start`  out  NUM_STAGES  FC compute start pulse.
- `fc_done`  in  NUM_STAGES  FC compute done.
- `stage_done`  out  NUM_STAGES  one-cycle pulse when stage i completes. Used to latch that stage's output vector.
- `busy`  out  1  high from the first step pulse until completion, error, or abort.
- `done`  out  1  one-cycle pulse on successful run completion.
- `error`  out  1  sticky timeout flag. Cleared by `rst` or by an accepted `start`.
- `err_stage`  out  3  stage index at timeout.
- `err_step`  out  2  step at timeout: 1 = weight, 2 = bias, 3 = compute. 0 = none.
- `run_cycles`  out  32  cycles from the first `wl_start` pulse to `done` of the last successful run. Saturates at 2^32−1.

## Operation
- States: IDLE, WLOAD, BLOAD, COMPUTE, ERROR. A 3-bit stage index `s`, a 32-bit wait counter, and a 32-bit run counter.
- IDLE:
  - `start`=1 → clear `error`, `err_stage`, `err_step`. Set s=0, go to WLOAD.
  - The step's start pulse issues on the first cycle of the step state.
- Each step state:
  - Cycle of entry: pulse the matching `*_start[s]` and zero the wait counter.
  - Following cycles: wait for `*_done[s]`. Done asserted during the entry (pulse) cycle is ignored as stale.
  - Done accepted → WLOAD goes to BLOAD, BLOAD goes to COMPUTE.
  - COMPUTE done with s<NUM_STAGES−1 → pulse `stage_done[s]`, increment s, go to WLOAD.
  - COMPUTE done with s=NUM_STAGES−1 → pulse `stage_done[s]` and `done`, latch `run_cycles`, go to IDLE.
- Only `*_done[s]` for the current stage is observed. Done bits of other stages are ignored.
- Timeout: if the wait counter reaches TIMEOUT_CYCLES without done, record `err_stage`=s and `err_step`, set `error`, and go to ERROR. No further start pulses are issued.
- ERROR: `busy`=0. Stays in ERROR until `start`, which behaves exactly as in IDLE, or `rst`.
- `abort` in any non-IDLE state → IDLE next cycle. No `done`, no `stage_done`, `error` unchanged, `run_cycles` unchanged. Any pulse scheduled for that cycle is suppressed.
- `start` while busy is ignored.
- Reset mid-run: every state and output returns to its reset value on the next edge. In-flight loaders are not cancelled; their later done pulses are ignored because the block is in IDLE.

## Timing
- Reset values: state IDLE, all `*_start`=0, `stage_done`=0, `busy`=0, `done`=0, `error`=0, `err_stage`=0, `err_step`=0, `run_cycles`=0.
- All outputs are registered.
- `start` sampled at edge T → `wl_start[0]` high during cycle T+1. `busy` rises at T+1.
- Done sampled high at edge D → next step's start pulse during cycle D+1. This gives a 1-cycle gap per handshake.
- Final `fc_done` sampled at D → `stage_done[last]`, `done`, and `busy`=0 all during cycle D+1.
- `run_cycles` counts cycles with `busy`=1. For loaders that return done exactly 1 cycle after their start pulse, the total is 6·NUM_STAGES.
- Timeout: a start pulse at cycle P with no done → `error`=1 and `busy`=0 in cycle P+TIMEOUT_CYCLES+1.
- Simultaneous `abort` and accepted done → abort wins.
- Simultaneous `rst` and anything → reset wins.

## Test plan
- **Nominal run.** NUM_STAGES=3; each done is pulsed 1 cycle after its start. → Pulse order `wl_start[0]`, `bl_start[0]`, `fc_start[0]`, `stage_done[0]`+`wl_start[1]`, and so on. `done` asserts once; `run_cycles`=18; `busy` drops with `done`.
- **Stale and cross-stage done.** Hold `wl_done[0]`=1 permanently and pulse `bl_done[1]` during stage 0. → WLOAD advances only on the cycle after the pulse cycle; the `bl_done[1]` pulse causes no transition.
- **Timeout.** TIMEOUT_CYCLES=10; `bl_done[1]` is never asserted. → 11 cycles after the `bl_start[1]` pulse: `error`=1, `err_stage`=1, `err_step`=2, `busy`=0. A following `start` clears `error` and restarts at stage 0.
- **Abort.** Assert `abort` in the same cycle that `fc_done[1]` is accepted. → No `stage_done[1]`, no `done`, IDLE next cycle, `run_cycles` holds the previous value.
- **Start while busy.** Assert `start` mid-run. → Ignored; the run completes normally with exactly one `done`.
- **Reset mid-run.** Assert `rst` during COMPUTE of stage 0. → All outputs at reset values next cycle; late `fc_done[0]` is ignored; the next `start` runs cleanly.
